// File: rtl/bcd_digit_entry_pkg.sv
// Shared types and constants for the BCD digit-entry block.
// Optional echo feature is enabled by defining BCD_DIGIT_ENTRY_ECHO_EN.
package bcd_digit_entry_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ENTRY = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Smallest width whose range covers every value of ndig decimal digits.
    function automatic int min_width(input int ndig);
        longint max_val = 1;
        int     w_min   = 63;
        for (int i = 0; i < ndig; i++) max_val = max_val * 10;
        max_val = max_val - 1;
        for (int w = 62; w >= 1; w--) begin
            if ((64'sd1 <<< w) > max_val) w_min = w;
        end
        return w_min;
    endfunction

endpackage

// File: rtl/bcd_digit_entry_if.sv
// Keypad/result bundle between the operator side (master) and the entry block (slave).
// echo_bcd exists only when BCD_DIGIT_ENTRY_ECHO_EN is defined.
interface bcd_digit_entry_if #(
    parameter int NDIG = 4,
    parameter int W    = 14
);
    logic [3:0]   digit_in;
    logic         key_digit_n;
    logic         key_enter_n;
    logic         key_clear_n;
    logic [W-1:0] value;
    logic         value_valid;
    logic [2:0]   digit_count;
    logic         err_digit;
    logic         err_ovf;
`ifdef BCD_DIGIT_ENTRY_ECHO_EN
    logic [4*NDIG-1:0] echo_bcd;

    modport master (
        output digit_in, key_digit_n, key_enter_n, key_clear_n,
        input  value, value_valid, digit_count, err_digit, err_ovf, echo_bcd
    );
    modport slave (
        input  digit_in, key_digit_n, key_enter_n, key_clear_n,
        output value, value_valid, digit_count, err_digit, err_ovf, echo_bcd
    );
`else
    modport master (
        output digit_in, key_digit_n, key_enter_n, key_clear_n,
        input  value, value_valid, digit_count, err_digit, err_ovf
    );
    modport slave (
        input  digit_in, key_digit_n, key_enter_n, key_clear_n,
        output value, value_valid, digit_count, err_digit, err_ovf
    );
`endif
endinterface

// File: rtl/bcd_digit_entry_key_press_det.sv
// Single-press detector for a debounced active-low key: one-cycle pulse on the falling edge.
// History flop resets to "released" so a key held through reset does not fire.
module key_press_det (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_press
);
    logic r_key_q;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_key_q <= 1'b1;
        else     r_key_q <= i_key_n;
    end

    assign o_press = r_key_q & ~i_key_n;
endmodule

// File: rtl/bcd_digit_entry.sv
// Keypad decimal entry: BCD digits appended via acc*10+d, ENTER publishes the binary value.
// Define BCD_DIGIT_ENTRY_ECHO_EN to add the echo_bcd shift register for display feedback.
module bcd_digit_entry
    import bcd_digit_entry_pkg::*;
#(
    parameter int NDIG = 4,
    parameter int W    = 14
) (
    input  logic             clk,
    input  logic             rst,
    bcd_digit_entry_if.slave bus
);
    if (W < min_width(NDIG) || NDIG < 1 || NDIG > 6) begin : g_param_err
        $error("bcd_digit_entry: NDIG out of 1..6 or W too narrow for NDIG digits");
    end

    localparam logic [2:0] NDIG_C = 3'(NDIG);

    logic w_clr, w_ent, w_dig, w_digit_ok;
    logic w_do_clear, w_do_publish, w_do_bad_digit, w_do_ovf, w_do_append, w_do_restart;
    state_e r_state, w_next_state;

    logic [W-1:0] r_acc;
    logic [W-1:0] r_value;
    logic         r_value_valid;
    logic [2:0]   r_count;
    logic         r_err_digit;
    logic         r_err_ovf;

    key_press_det u_det_digit (.clk(clk), .rst(rst), .i_key_n(bus.key_digit_n), .o_press(w_dig));
    key_press_det u_det_enter (.clk(clk), .rst(rst), .i_key_n(bus.key_enter_n), .o_press(w_ent));
    key_press_det u_det_clear (.clk(clk), .rst(rst), .i_key_n(bus.key_clear_n), .o_press(w_clr));

    assign w_digit_ok = (bus.digit_in <= BCD_MAX);

    always_ff @(posedge clk) begin
        if (rst) r_state <= EMPTY;
        else     r_state <= w_next_state;
    end

    // Priority clear > enter > digit; lower-priority presses in the same cycle are dropped.
    always_comb begin
        w_next_state = r_state;
        if (w_clr) begin
            w_next_state = EMPTY;
        end else if (w_ent) begin
            w_next_state = DONE;
        end else if (w_dig && w_digit_ok) begin
            if (r_state == DONE || r_count < NDIG_C) w_next_state = ENTRY;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_do_clear     = 1'b0;
        w_do_publish   = 1'b0;
        w_do_bad_digit = 1'b0;
        w_do_ovf       = 1'b0;
        w_do_append    = 1'b0;
        w_do_restart   = 1'b0;
        if (w_clr) begin
            w_do_clear = 1'b1;
        end else if (w_ent) begin
            w_do_publish = 1'b1;
        end else if (w_dig) begin
            if (!w_digit_ok)               w_do_bad_digit = 1'b1;
            else if (r_state == DONE)      w_do_restart   = 1'b1;
            else if (r_count == NDIG_C)    w_do_ovf       = 1'b1;
            else                           w_do_append    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc         <= '0;
            r_value       <= '0;
            r_value_valid <= 1'b0;
            r_count       <= 3'd0;
            r_err_digit   <= 1'b0;
            r_err_ovf     <= 1'b0;
        end else begin
            r_value_valid <= w_do_publish;
            if (w_do_clear) begin
                r_acc       <= '0;
                r_count     <= 3'd0;
                r_err_digit <= 1'b0;
                r_err_ovf   <= 1'b0;
            end
            if (w_do_publish)   r_value     <= r_acc;
            if (w_do_bad_digit) r_err_digit <= 1'b1;
            if (w_do_ovf)       r_err_ovf   <= 1'b1;
            if (w_do_append) begin
                r_acc   <= (r_acc << 3) + (r_acc << 1) + W'(bus.digit_in);
                r_count <= r_count + 3'd1;
            end
            if (w_do_restart) begin
                r_acc       <= W'(bus.digit_in);
                r_count     <= 3'd1;
                r_err_digit <= 1'b0;
                r_err_ovf   <= 1'b0;
            end
        end
    end

`ifdef BCD_DIGIT_ENTRY_ECHO_EN
    logic [4*NDIG-1:0] r_echo;

    always_ff @(posedge clk) begin
        if (rst || w_do_clear) r_echo <= '0;
        else if (w_do_append)  r_echo <= (r_echo << 4) | (4*NDIG)'(bus.digit_in);
        else if (w_do_restart) r_echo <= (4*NDIG)'(bus.digit_in);
    end

    assign bus.echo_bcd = r_echo;
`endif

    assign bus.value       = r_value;
    assign bus.value_valid = r_value_valid;
    assign bus.digit_count = r_count;
    assign bus.err_digit   = r_err_digit;
    assign bus.err_ovf     = r_err_ovf;
endmodule

// File: tb/tb_bcd_digit_entry.sv
// Directed self-checking bench for bcd_digit_entry; echo checks run when
// BCD_DIGIT_ENTRY_ECHO_EN is defined.
module tb_bcd_digit_entry;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   pulses = 0;

    bcd_digit_entry_if #(.NDIG(4), .W(14)) bus ();

    bcd_digit_entry #(.NDIG(4), .W(14)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.value_valid === 1'b1) pulses++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press_digit(input logic [3:0] d);
        bus.digit_in    = d;
        bus.key_digit_n = 1'b0;
        tick();
        bus.key_digit_n = 1'b1;
        tick();
    endtask

    task automatic press_enter();
        bus.key_enter_n = 1'b0;
        tick();
        bus.key_enter_n = 1'b1;
        tick();
    endtask

    task automatic press_clear();
        bus.key_clear_n = 1'b0;
        tick();
        bus.key_clear_n = 1'b1;
        tick();
    endtask

    initial begin
        int base;
        bus.digit_in    = 4'd0;
        bus.key_digit_n = 1'b1;
        bus.key_enter_n = 1'b1;
        bus.key_clear_n = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1: reset state, then 1,2,3,4 + enter
        check("rst_value", 32'(bus.value), 32'd0);
        check("rst_valid", 32'(bus.value_valid), 32'd0);
        check("rst_count", 32'(bus.digit_count), 32'd0);
        check("rst_err_digit", 32'(bus.err_digit), 32'd0);
        check("rst_err_ovf", 32'(bus.err_ovf), 32'd0);
        press_digit(4'd1);
        check("count_after_1", 32'(bus.digit_count), 32'd1);
        press_digit(4'd2);
        press_digit(4'd3);
        press_digit(4'd4);
        check("count_after_4", 32'(bus.digit_count), 32'd4);
        base = pulses;
        bus.key_enter_n = 1'b0;
        tick();
        check("enter_value_1234", 32'(bus.value), 32'h4D2);
        check("enter_valid_hi", 32'(bus.value_valid), 32'd1);
        bus.key_enter_n = 1'b1;
        tick();
        check("enter_valid_lo", 32'(bus.value_valid), 32'd0);
        check("one_pulse", 32'(pulses - base), 32'd1);
        check("count_kept_done", 32'(bus.digit_count), 32'd4);

        // 2: overflow on fifth digit
        press_clear();
        press_digit(4'd1);
        press_digit(4'd2);
        press_digit(4'd3);
        press_digit(4'd4);
        press_digit(4'd5);
        check("ovf_flag", 32'(bus.err_ovf), 32'd1);
        check("ovf_count", 32'(bus.digit_count), 32'd4);
        press_enter();
        check("ovf_value", 32'(bus.value), 32'd1234);
        press_clear();
        check("clear_ovf", 32'(bus.err_ovf), 32'd0);
        check("clear_count", 32'(bus.digit_count), 32'd0);
        check("clear_keeps_value", 32'(bus.value), 32'd1234);

        // 3: non-BCD digit then 7
        press_digit(4'hB);
        check("bad_digit_flag", 32'(bus.err_digit), 32'd1);
        check("bad_digit_count", 32'(bus.digit_count), 32'd0);
        press_digit(4'd7);
        check("after_bad_count", 32'(bus.digit_count), 32'd1);
        check("err_digit_sticky", 32'(bus.err_digit), 32'd1);
        press_enter();
        check("value_7", 32'(bus.value), 32'd7);

        // 4: held digit key gives one press (DONE -> new entry)
        bus.digit_in    = 4'd3;
        bus.key_digit_n = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        bus.key_digit_n = 1'b1;
        tick();
        check("hold_count", 32'(bus.digit_count), 32'd1);
        check("restart_clears_err", 32'(bus.err_digit), 32'd0);
        press_enter();
        check("hold_value", 32'(bus.value), 32'd3);

        // 5: clear + enter + digit together
        base = pulses;
        bus.digit_in    = 4'd8;
        bus.key_clear_n = 1'b0;
        bus.key_enter_n = 1'b0;
        bus.key_digit_n = 1'b0;
        tick();
        check("combo_count", 32'(bus.digit_count), 32'd0);
        check("combo_valid", 32'(bus.value_valid), 32'd0);
        bus.key_clear_n = 1'b1;
        bus.key_enter_n = 1'b1;
        bus.key_digit_n = 1'b1;
        tick();
        check("combo_no_pulse", 32'(pulses - base), 32'd0);
        check("combo_value_kept", 32'(bus.value), 32'd3);

        // 6: enter in EMPTY publishes 0; reset mid-entry
        bus.key_enter_n = 1'b0;
        tick();
        check("empty_enter_value", 32'(bus.value), 32'd0);
        check("empty_enter_valid", 32'(bus.value_valid), 32'd1);
        bus.key_enter_n = 1'b1;
        tick();
        press_clear();
        press_digit(4'd9);
        press_digit(4'd9);
        press_digit(4'd9);
        press_digit(4'd9);
        press_enter();
        check("max_value_9999", 32'(bus.value), 32'd9999);
        press_clear();
        press_digit(4'd4);
        press_digit(4'd2);
        check("pre_rst_count", 32'(bus.digit_count), 32'd2);
        base = pulses;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("midrst_value", 32'(bus.value), 32'd9999 & 32'd0);
        check("midrst_count", 32'(bus.digit_count), 32'd0);
        check("midrst_valid", 32'(bus.value_valid), 32'd0);
        check("midrst_no_pulse", 32'(pulses - base), 32'd0);
        press_enter();
        check("acc_discarded", 32'(bus.value), 32'd0);

`ifdef BCD_DIGIT_ENTRY_ECHO_EN
        press_clear();
        check("echo_cleared", 32'(bus.echo_bcd), 32'd0);
        press_digit(4'd9);
        press_digit(4'd0);
        press_digit(4'd5);
        check("echo_905", 32'(bus.echo_bcd), 32'h0905);
        press_enter();
        check("value_905", 32'(bus.value), 32'd905);
        press_digit(4'd6);
        check("echo_restart", 32'(bus.echo_bcd), 32'h0006);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
